// File: rtl/data_sram_resp.sv
// data_sram_resp: the responder end of the CPU's SRAM-style memory port.
// The memory is organised as 32-bit words, and writes are done per byte lane.
// Read data is registered and appears one cycle after the request edge.
// After reset, a clear sequence writes INIT_VAL into every word.
// Requests are honoured only once that clear sequence has finished.
//
// Optional build macro SRAM_RANGE_CHK_EN:
//   When defined, requests outside the BASE window are rejected with a
//   one-cycle err pulse and zero read data.
//   When undefined, the upper address bits alias onto the array and err is 0.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | writing INIT_VAL to mem[clr_idx]; requests dropped silently
// ST_READY | terminal; requests served with one-cycle read latency
module data_sram_resp #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000,
  parameter logic [31:0] BASE     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_idx;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       mem [0:DEPTH-1];
  logic [31:0]       merged;
  logic              in_win;
  logic              clr_we;
  logic              acc_rd;
  logic              acc_wr;
  logic              acc_bad;

  assign idx = addr[ADDR_W+1:2];

`ifdef SRAM_RANGE_CHK_EN
  localparam logic [31:0] WIN_MASK = 32'((64'd1 << (ADDR_W + 2)) - 64'd1);
  assign in_win = ((addr & ~WIN_MASK) == BASE);
  logic unused_addr;
  assign unused_addr = ^addr[1:0];
`else
  assign in_win = 1'b1;
  // Upper address bits alias in this build, and the byte offset is never used.
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0], BASE};
`endif

  // State register, clear index and registered ready flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next == ST_READY);
      if (state == ST_CLEAR) begin
        clr_idx <= clr_idx + ADDR_W'(1);
      end
    end
  end

  // Next state: leave CLEAR once the last word has been written.
  always_comb begin
    state_next = state;
    if (state == ST_CLEAR && clr_idx == LAST_IDX) begin
      state_next = ST_READY;
    end
  end

  // Output decode: clear write, or classify the current request.
  always_comb begin
    clr_we  = 1'b0;
    acc_rd  = 1'b0;
    acc_wr  = 1'b0;
    acc_bad = 1'b0;
    if (state == ST_CLEAR) begin
      clr_we = 1'b1;
    end else if (en) begin
      if (!in_win) begin
        acc_bad = 1'b1;
      end else if (wen == 4'b0000) begin
        acc_rd = 1'b1;
      end else begin
        acc_wr = 1'b1;
      end
    end
  end

  // Byte-lane merge of write data into the currently stored word.
  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Array update: the clear sequence writes INIT_VAL, and in-window writes store the merged word.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= INIT_VAL;
    end else if (acc_wr) begin
      mem[idx] <= merged;
    end
  end

  // Registered read data. A write returns its merged word (write-first); otherwise the value holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (acc_rd) begin
      rdata <= mem[idx];
    end else if (acc_wr) begin
      rdata <= merged;
    end else if (acc_bad) begin
      rdata <= '0;
    end
  end

`ifdef SRAM_RANGE_CHK_EN
  // err pulses for one cycle on each out-of-window request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= acc_bad;
    end
  end
`else
  assign err = 1'b0;
  logic unused_bad;
  assign unused_bad = acc_bad;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed testbench for data_sram_resp with ADDR_W=4 and INIT_VAL=A5A5A5A5.
// Expected values depend on whether SRAM_RANGE_CHK_EN is defined.
module tb_data_sram_resp;

  localparam int          ADDR_W   = 4;
  localparam logic [31:0] INIT_VAL = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int checks = 0;
  int errors = 0;

  data_sram_resp #(.ADDR_W(ADDR_W), .INIT_VAL(INIT_VAL), .BASE(32'h0)) dut (
    .clk(clk), .reset(reset), .en(en), .wen(wen), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  // One request through a single active edge; outputs can be sampled when it returns.
  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    en = 1'b1; wen = w; addr = a; wdata = d;
    @(posedge clk); #1;
    en = 1'b0; wen = 4'h0;
  endtask

  // Releases reset and counts cycles until ready. Optionally injects a write at a chosen cycle.
  // Flags any nonzero rdata or err seen while clearing.
  task automatic wait_ready(input int inject_at, output int cycles, output bit bad_rd);
    bad_rd = 1'b0;
    cycles = 0;
    reset = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (n == inject_at) begin
        en = 1'b1; wen = 4'hF; addr = 32'h0; wdata = 32'h1234_5678;
      end
      @(posedge clk); #1;
      en = 1'b0; wen = 4'h0;
      cycles = n;
      if (ready) break;
      if (rdata !== 32'h0 || err !== 1'b0) bad_rd = 1'b1;
    end
  endtask

  task automatic test_reset;
    int cyc; bit bad;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b rdata=%h err=%b, required 0/0/0", ready, rdata, err);
    end
    wait_ready(0, cyc, bad);
    checks++;
    if (cyc !== 16 || ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_length: ready after %0d cycles (ready=%b), required 16", cyc, ready);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL clear_rdata: nonzero rdata/err during CLEAR, required 0");
    end
    access(32'h0, 4'h0, 32'h0);
    checks++;
    if (rdata !== INIT_VAL) begin
      errors++;
      $display("FAIL init_word0: rdata=%h, required %h", rdata, INIT_VAL);
    end
    access(32'h3C, 4'h0, 32'h0);
    checks++;
    if (rdata !== INIT_VAL) begin
      errors++;
      $display("FAIL init_word15: rdata=%h, required %h", rdata, INIT_VAL);
    end
  endtask

  task automatic test_full_write;
    access(32'h8, 4'hF, 32'h1234_5678);
    checks++;
    if (rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_first: rdata=%h, required 12345678", rdata);
    end
    access(32'h0, 4'h0, 32'h0);
    access(32'h8, 4'h0, 32'h0);
    checks++;
    if (rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL full_read: rdata=%h, required 12345678", rdata);
    end
  endtask

  task automatic test_byte_lanes;
    access(32'hC, 4'hF, 32'h1122_3344);
    access(32'hC, 4'b0101, 32'hAABB_CCDD);
    checks++;
    if (rdata !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL lane_merge_wr: rdata=%h, required 11BB33DD", rdata);
    end
    access(32'hC, 4'h0, 32'h0);
    checks++;
    if (rdata !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL lane_merge_rd: rdata=%h, required 11BB33DD", rdata);
    end
    access(32'hC, 4'b1010, 32'h5566_7788);
    access(32'hC, 4'h0, 32'h0);
    checks++;
    if (rdata !== 32'h55BB_77DD) begin
      errors++;
      $display("FAIL lane_merge_hi: rdata=%h, required 55BB77DD", rdata);
    end
  endtask

  task automatic test_idle;
    access(32'h8, 4'h0, 32'h0);
    en = 1'b0; wen = 4'hF; addr = 32'h8; wdata = 32'hFFFF_0000;
    repeat (2) @(posedge clk);
    #1;
    wen = 4'h0;
    checks++;
    if (rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL idle_hold: rdata=%h, required 12345678", rdata);
    end
    access(32'h8, 4'h0, 32'h0);
    checks++;
    if (rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL idle_nowrite: rdata=%h, required 12345678", rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [4];
    vals[0] = 32'h0101_0101; vals[1] = 32'h2222_3333;
    vals[2] = 32'h4455_6677; vals[3] = 32'h89AB_CDEF;
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; wen = 4'hF; addr = 32'(16 + 4*i); wdata = vals[i];
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; wen = 4'h0; addr = 32'(16 + 4*i);
      @(posedge clk); #1;
      checks++;
      if (rdata !== vals[i]) begin
        errors++;
        $display("FAIL b2b_read%0d: rdata=%h, required %h", i, rdata, vals[i]);
      end
    end
    en = 1'b1; wen = 4'b0011; addr = 32'h14; wdata = 32'h0000_BEEF;
    @(posedge clk); #1;
    wen = 4'h0;
    @(posedge clk); #1;
    en = 1'b0;
    checks++;
    if (rdata !== 32'h2222_BEEF) begin
      errors++;
      $display("FAIL wr_then_rd: rdata=%h, required 2222BEEF", rdata);
    end
  endtask

  task automatic test_clear_request;
    int cyc; bit bad;
    reset = 1'b0;
    @(posedge clk); #1;
    wait_ready(3, cyc, bad);
    checks++;
    if (cyc !== 16 || bad) begin
      errors++;
      $display("FAIL clear_drop: ready after %0d cycles, bad=%b, required 16/0", cyc, bad);
    end
    access(32'h0, 4'h0, 32'h0);
    checks++;
    if (rdata !== INIT_VAL) begin
      errors++;
      $display("FAIL clear_drop_word0: rdata=%h, required %h", rdata, INIT_VAL);
    end
  endtask

  task automatic test_reset_mid;
    int cyc; bit bad;
    access(32'h8, 4'hF, 32'hDEAD_BEEF);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: ready=%b rdata=%h, required 0/0", ready, rdata);
    end
    @(posedge clk); #1;
    wait_ready(0, cyc, bad);
    checks++;
    if (cyc !== 16 || bad) begin
      errors++;
      $display("FAIL reclear_length: ready after %0d cycles, bad=%b, required 16/0", cyc, bad);
    end
    access(32'h8, 4'h0, 32'h0);
    checks++;
    if (rdata !== INIT_VAL) begin
      errors++;
      $display("FAIL reclear_word2: rdata=%h, required %h", rdata, INIT_VAL);
    end
  endtask

  task automatic test_range;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_w0;
`ifdef SRAM_RANGE_CHK_EN
    exp_rd = 32'h0; exp_err = 1'b1; exp_w0 = INIT_VAL;
`else
    exp_rd = 32'hFFFF_FFFF; exp_err = 1'b0; exp_w0 = 32'hFFFF_FFFF;
`endif
    access(32'h40, 4'hF, 32'hFFFF_FFFF);
    checks++;
    if (rdata !== exp_rd || err !== exp_err) begin
      errors++;
      $display("FAIL oow_write: rdata=%h err=%b, required %h/%b", rdata, err, exp_rd, exp_err);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle: err=%b, required 0", err);
    end
    access(32'h0, 4'h0, 32'h0);
    checks++;
    if (rdata !== exp_w0 || err !== 1'b0) begin
      errors++;
      $display("FAIL word0_after_oow: rdata=%h err=%b, required %h/0", rdata, err, exp_w0);
    end
    access(32'h3C, 4'hF, 32'h0F0F_0F0F);
    checks++;
    if (rdata !== 32'h0F0F_0F0F || err !== 1'b0) begin
      errors++;
      $display("FAIL edge_in_window: rdata=%h err=%b, required 0F0F0F0F/0", rdata, err);
    end
    en = 1'b1; wen = 4'h0; addr = 32'h8000_0004;
    @(posedge clk); #1;
    en = 1'b1; wen = 4'h0; addr = 32'h44;
    @(posedge clk); #1;
    en = 1'b0;
`ifdef SRAM_RANGE_CHK_EN
    exp_rd = 32'h0; exp_err = 1'b1;
`else
    exp_rd = INIT_VAL; exp_err = 1'b0;
`endif
    checks++;
    if (rdata !== exp_rd || err !== exp_err) begin
      errors++;
      $display("FAIL oow_read_pair: rdata=%h err=%b, required %h/%b", rdata, err, exp_rd, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_byte_lanes();
    test_idle();
    test_back_to_back();
    test_clear_request();
    test_reset_mid();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
